// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter handing one byte at a time from NUM_REQ requesters to a UART transmitter.
module uart_tx_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 2000
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [NUM_REQ-1:0]   Req,
  input  logic [8*NUM_REQ-1:0] Req_data,
  output logic [NUM_REQ-1:0]   Ack,
  output logic [NUM_REQ-1:0]   Done,
  output logic [7:0]           Tx_data,
  output logic                 Tx_data_vld,
  input  logic                 Tx_send_done,
  output logic                 Busy,
  output logic                 Err_timeout,
  input  logic                 Err_clr
);
  localparam int W = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;
  state_t state, state_nxt;
  logic [W-1:0] rr_ptr, win, pick, off;
  logic [W:0] sum, ptr_inc;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0] rot, win_oh;
  logic [23:0] cnt;
  logic grant, sent, expired, gap_end;
  // Rotate requests so bit 0 is the requester at rr_ptr; the lowest set bit is the winner.
  assign dbl = {Req, Req};
  assign rot = dbl[rr_ptr +: NUM_REQ];
  always_comb begin
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (rot[k]) off = W'(k);
  end
  assign sum     = {1'b0, rr_ptr} + {1'b0, off};
  assign pick    = sum >= (W+1)'(NUM_REQ) ? W'(sum - (W+1)'(NUM_REQ)) : sum[W-1:0];
  assign ptr_inc = {1'b0, win} + (W+1)'(1);
  assign win_oh  = NUM_REQ'(1) << win;
  assign grant   = state == IDLE && |Req;
  assign sent    = state == WAIT_DONE && Tx_send_done;
  assign expired = state == WAIT_DONE && !Tx_send_done && cnt == 24'(TIMEOUT - 1);
  assign gap_end = state == GAP && cnt == 24'(GAP_CYCLES - 1);
  assign Tx_data_vld = state == ISSUE;
  assign Ack         = Tx_data_vld ? win_oh : '0;
  assign Busy        = state != IDLE;
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:      state_nxt = grant ? ISSUE : IDLE;
      ISSUE:     state_nxt = WAIT_DONE;
      WAIT_DONE: state_nxt = (sent || expired) ? (GAP_CYCLES == 0 ? IDLE : GAP) : WAIT_DONE;
      GAP:       state_nxt = gap_end ? IDLE : GAP;
      default:   state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      rr_ptr      <= '0;
      win         <= '0;
      Tx_data     <= '0;
      cnt         <= '0;
      Done        <= '0;
      Err_timeout <= 1'b0;
    end else begin
      cnt         <= (state_nxt == state && (state == WAIT_DONE || state == GAP)) ? cnt + 24'd1 : '0;
      Done        <= sent ? win_oh : '0;
      Err_timeout <= expired | (Err_timeout & ~Err_clr);
      if (grant) begin
        win     <= pick;
        Tx_data <= Req_data[{pick, 3'b000} +: 8];
      end
      if (state == ISSUE) rr_ptr <= ptr_inc == (W+1)'(NUM_REQ) ? '0 : ptr_inc[W-1:0];
    end
endmodule
